// File: rtl/l2_cache_way_sel_pkg.sv
// Shared L2 cache definitions: geometry constants and the way-select FSM state type.
// Imported by the way-select interface and RTL.
package cache_def;

  localparam int unsigned INDEX_L2     = 10;  // set index width
  localparam int unsigned INDEX_WAY_L2 = 3;   // way index width
  localparam int unsigned WAYS_L2      = 8;   // associativity (tree pLRU needs 8)

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    WB     = 3'd2,
    REFILL = 3'd3,
    TOUCH  = 3'd4
  } way_sel_state_e;

endpackage

// File: rtl/l2_cache_way_sel_if.sv
// Bundle of lookup request, pLRU, writeback, refill, response and perf signals
// for l2_cache_way_sel.
//   slave  : the way-select controller
//   master : requester / pLRU / memory side
interface l2_cache_way_sel_if
  import cache_def::*;
#(
  parameter int unsigned WAYS    = WAYS_L2,
  parameter int unsigned WAY_W   = INDEX_WAY_L2,
  parameter int unsigned INDEX_W = INDEX_L2
);

  logic               req_valid_i;
  logic               req_ready_o;
  logic [INDEX_W-1:0] req_index_i;
  logic [WAYS-1:0]    tag_hit_i;
  logic [WAYS-1:0]    way_valid_i;
  logic [WAYS-1:0]    way_dirty_i;
  logic [WAY_W-1:0]   plru_victim_i;
  logic               plru_valid_o;
  logic [INDEX_W-1:0] plru_index_o;
  logic [WAY_W-1:0]   plru_way_o;
  logic               wb_req_o;
  logic [WAY_W-1:0]   wb_way_o;
  logic               wb_ack_i;
  logic               refill_req_o;
  logic [WAY_W-1:0]   refill_way_o;
  logic               refill_ack_i;
  logic               resp_valid_o;
  logic               resp_hit_o;
  logic [WAY_W-1:0]   resp_way_o;
  logic [31:0]        perf_hit_o;
  logic [31:0]        perf_miss_o;
  logic [31:0]        perf_wb_o;

  modport slave (
    input  req_valid_i, req_index_i, tag_hit_i, way_valid_i, way_dirty_i,
           plru_victim_i, wb_ack_i, refill_ack_i,
    output req_ready_o, plru_valid_o, plru_index_o, plru_way_o,
           wb_req_o, wb_way_o, refill_req_o, refill_way_o,
           resp_valid_o, resp_hit_o, resp_way_o,
           perf_hit_o, perf_miss_o, perf_wb_o
  );

  modport master (
    output req_valid_i, req_index_i, tag_hit_i, way_valid_i, way_dirty_i,
           plru_victim_i, wb_ack_i, refill_ack_i,
    input  req_ready_o, plru_valid_o, plru_index_o, plru_way_o,
           wb_req_o, wb_way_o, refill_req_o, refill_way_o,
           resp_valid_o, resp_hit_o, resp_way_o,
           perf_hit_o, perf_miss_o, perf_wb_o
  );

endinterface

// File: rtl/l2_cache_way_sel_first_one.sv
// Lowest-set-bit priority encoder with a found flag.
//   vec   : input bit vector
//   idx   : index of the lowest set bit (0 when none)
//   found : any bit set
module l2_way_first_one #(
  parameter int unsigned WAYS  = 8,
  parameter int unsigned WAY_W = 3
) (
  input  logic [WAYS-1:0]  vec,
  output logic [WAY_W-1:0] idx,
  output logic             found
);

  // Scan high to low so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = int'(WAYS) - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = WAY_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/l2_cache_way_sel.sv
// L2 way-selection / replacement controller. Picks the hit way, else the
// lowest invalid way, else the pLRU victim; sequences writeback and refill,
// then issues a single-cycle pLRU touch plus response.
// Ports:
//   clk_i : clock
//   rst_i : asynchronous active-high reset
//   bus   : l2_cache_way_sel_if.slave (request, pLRU, wb, refill, resp, perf)
// Optional: define L2_WAY_SEL_PERF_EN to build saturating hit/miss/writeback
// counters; otherwise the perf outputs are tied to 0.
module l2_cache_way_sel
  import cache_def::*;
#(
  parameter int unsigned WAYS    = WAYS_L2,
  parameter int unsigned WAY_W   = INDEX_WAY_L2,
  parameter int unsigned INDEX_W = INDEX_L2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  l2_cache_way_sel_if.slave  bus
);

  way_sel_state_e state, state_nxt;

  logic [INDEX_W-1:0] index_r;
  logic [WAYS-1:0]    hit_vec_r;
  logic [WAYS-1:0]    valid_r;
  logic [WAYS-1:0]    dirty_r;
  logic [WAY_W-1:0]   way_r;
  logic               hit_r;

  logic [WAYS-1:0]    invalid_vec;
  logic [WAY_W-1:0]   hit_way;
  logic [WAY_W-1:0]   inv_way;
  logic               hit_found;
  logic               inv_found;
  logic               accept;

  assign invalid_vec = ~valid_r;
  assign accept      = bus.req_valid_i & bus.req_ready_o;

  l2_way_first_one #(.WAYS(WAYS), .WAY_W(WAY_W)) u_hit_sel (
    .vec   (hit_vec_r),
    .idx   (hit_way),
    .found (hit_found)
  );

  l2_way_first_one #(.WAYS(WAYS), .WAY_W(WAY_W)) u_inv_sel (
    .vec   (invalid_vec),
    .idx   (inv_way),
    .found (inv_found)
  );

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = LOOKUP;
      LOOKUP: begin
        if (hit_found)                    state_nxt = TOUCH;
        else if (inv_found)               state_nxt = REFILL;
        else if (dirty_r[bus.plru_victim_i]) state_nxt = WB;
        else                              state_nxt = REFILL;
      end
      WB:      if (bus.wb_ack_i)     state_nxt = REFILL;
      REFILL:  if (bus.refill_ack_i) state_nxt = TOUCH;
      TOUCH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture and way decision
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      index_r   <= '0;
      hit_vec_r <= '0;
      valid_r   <= '0;
      dirty_r   <= '0;
      way_r     <= '0;
      hit_r     <= 1'b0;
    end else begin
      if (accept) begin
        index_r   <= bus.req_index_i;
        hit_vec_r <= bus.tag_hit_i;
        valid_r   <= bus.way_valid_i;
        dirty_r   <= bus.way_dirty_i;
      end
      if (state == LOOKUP) begin
        hit_r <= hit_found;
        if (hit_found)      way_r <= hit_way;
        else if (inv_found) way_r <= inv_way;
        else                way_r <= bus.plru_victim_i;
      end
    end
  end

  // Outputs decoded from state and registers only
  always_comb begin
    bus.req_ready_o  = (state == IDLE) & ~rst_i;
    bus.plru_index_o = index_r;
    bus.plru_valid_o = 1'b0;
    bus.plru_way_o   = '0;
    bus.wb_req_o     = 1'b0;
    bus.wb_way_o     = '0;
    bus.refill_req_o = 1'b0;
    bus.refill_way_o = '0;
    bus.resp_valid_o = 1'b0;
    bus.resp_hit_o   = 1'b0;
    bus.resp_way_o   = '0;
    case (state)
      WB: begin
        bus.wb_req_o = 1'b1;
        bus.wb_way_o = way_r;
      end
      REFILL: begin
        bus.refill_req_o = 1'b1;
        bus.refill_way_o = way_r;
      end
      TOUCH: begin
        bus.plru_valid_o = 1'b1;
        bus.plru_way_o   = way_r;
        bus.resp_valid_o = 1'b1;
        bus.resp_hit_o   = hit_r;
        bus.resp_way_o   = way_r;
      end
      default: ;
    endcase
  end

`ifdef L2_WAY_SEL_PERF_EN
  logic [31:0] perf_hit_r;
  logic [31:0] perf_miss_r;
  logic [31:0] perf_wb_r;

  // Saturating event counters
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_hit_r  <= '0;
      perf_miss_r <= '0;
      perf_wb_r   <= '0;
    end else begin
      if ((state == TOUCH) && hit_r && (perf_hit_r != '1))
        perf_hit_r <= perf_hit_r + 32'd1;
      if ((state == TOUCH) && !hit_r && (perf_miss_r != '1))
        perf_miss_r <= perf_miss_r + 32'd1;
      if ((state == WB) && bus.wb_ack_i && (perf_wb_r != '1))
        perf_wb_r <= perf_wb_r + 32'd1;
    end
  end

  assign bus.perf_hit_o  = perf_hit_r;
  assign bus.perf_miss_o = perf_miss_r;
  assign bus.perf_wb_o   = perf_wb_r;
`else
  assign bus.perf_hit_o  = '0;
  assign bus.perf_miss_o = '0;
  assign bus.perf_wb_o   = '0;
`endif

endmodule

// File: tb/tb_l2_cache_way_sel.sv
// Self-checking bench for l2_cache_way_sel: requests push expected responses
// to a scoreboard; a negedge monitor pops and compares on every response.
module tb_l2_cache_way_sel;
  import cache_def::*;

  localparam int unsigned WAYS    = WAYS_L2;
  localparam int unsigned WAY_W   = INDEX_WAY_L2;
  localparam int unsigned INDEX_W = INDEX_L2;

  typedef struct packed {
    logic               hit;
    logic [WAY_W-1:0]   way;
    logic [INDEX_W-1:0] index;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  l2_cache_way_sel_if #(.WAYS(WAYS), .WAY_W(WAY_W), .INDEX_W(INDEX_W)) bus ();

  l2_cache_way_sel #(.WAYS(WAYS), .WAY_W(WAY_W), .INDEX_W(INDEX_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference way choice: lowest hit, else lowest invalid, else victim.
  function automatic void model(input logic [WAYS-1:0] hit, input logic [WAYS-1:0] valid,
                                input logic [WAYS-1:0] dirty, input logic [WAY_W-1:0] vic,
                                output logic h, output logic [WAY_W-1:0] w, output logic wb);
    logic inv;
    h   = 1'b0;
    inv = 1'b0;
    w   = vic;
    wb  = 1'b0;
    for (int i = int'(WAYS) - 1; i >= 0; i--)
      if (hit[i]) begin h = 1'b1; w = WAY_W'(i); end
    if (!h) begin
      for (int i = int'(WAYS) - 1; i >= 0; i--)
        if (!valid[i]) begin inv = 1'b1; w = WAY_W'(i); end
      if (!inv) wb = dirty[vic];
    end
  endfunction

  // Response monitor
  always @(negedge clk) begin
    if (!rst && bus.resp_valid_o) begin : mon
      exp_t e;
      if (sb.size() == 0) begin
        chk("resp_unexpected", 32'(bus.resp_valid_o), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("resp_hit",   32'(bus.resp_hit_o),   32'(e.hit));
        chk("resp_way",   32'(bus.resp_way_o),   32'(e.way));
        chk("plru_valid", 32'(bus.plru_valid_o), 32'd1);
        chk("plru_way",   32'(bus.plru_way_o),   32'(e.way));
        chk("plru_index", 32'(bus.plru_index_o), 32'(e.index));
      end
    end
    if (!rst && bus.plru_valid_o && !bus.resp_valid_o)
      chk("touch_without_resp", 32'(bus.plru_valid_o), 32'd0);
  end

  // Bounded wait at negedge for ready (0), wb_req (1) or refill_req (2)
  task automatic wait_hi(input int sel, input string tag);
    logic s;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      s = (sel == 0) ? bus.req_ready_o : (sel == 1) ? bus.wb_req_o : bus.refill_req_o;
      if (s) return;
    end
    chk({tag, "_timeout"}, 32'(s), 32'd1);
  endtask

  task automatic drive_req(input logic [INDEX_W-1:0] idx, input logic [WAYS-1:0] hit,
                           input logic [WAYS-1:0] valid, input logic [WAYS-1:0] dirty,
                           input logic [WAY_W-1:0] vic);
    wait_hi(0, "ready");
    bus.req_valid_i   = 1'b1;
    bus.req_index_i   = idx;
    bus.tag_hit_i     = hit;
    bus.way_valid_i   = valid;
    bus.way_dirty_i   = dirty;
    bus.plru_victim_i = vic;
    @(posedge clk);
    #1;
    // Scramble request fields so the DUT must rely on its captured copy.
    bus.req_valid_i = 1'b0;
    bus.req_index_i = ~idx;
    bus.tag_hit_i   = '0;
    bus.way_valid_i = ~valid;
    bus.way_dirty_i = ~dirty;
  endtask

  task automatic do_req(input logic [INDEX_W-1:0] idx, input logic [WAYS-1:0] hit,
                        input logic [WAYS-1:0] valid, input logic [WAYS-1:0] dirty,
                        input logic [WAY_W-1:0] vic, input int wb_dly, input int rf_dly);
    logic h, wb;
    logic [WAY_W-1:0] w;
    exp_t e;
    model(hit, valid, dirty, vic, h, w, wb);
    e.hit = h; e.way = w; e.index = idx;
    sb.push_back(e);
    drive_req(idx, hit, valid, dirty, vic);
    if (h) begin
      @(negedge clk);
      chk("lookup_no_resp", 32'(bus.resp_valid_o), 32'd0);
      @(negedge clk);
      chk("hit_latency",   32'(bus.resp_valid_o), 32'd1);
      chk("hit_no_wb",     32'(bus.wb_req_o),     32'd0);
      chk("hit_no_refill", 32'(bus.refill_req_o), 32'd0);
      @(negedge clk);
      chk("ready_after_hit", 32'(bus.req_ready_o), 32'd1);
    end else begin
      if (wb) begin
        wait_hi(1, "wb_req");
        chk("wb_way",        32'(bus.wb_way_o),     32'(w));
        chk("wb_no_refill",  32'(bus.refill_req_o), 32'd0);
        for (int i = 0; i < wb_dly; i++) begin
          @(negedge clk);
          chk("wb_hold", 32'(bus.wb_req_o), 32'd1);
        end
        bus.wb_ack_i = 1'b1;
        @(posedge clk);
        #1 bus.wb_ack_i = 1'b0;
      end
      wait_hi(2, "refill_req");
      chk("refill_way",    32'(bus.refill_way_o), 32'(w));
      chk("refill_no_wb",  32'(bus.wb_req_o),     32'd0);
      for (int i = 0; i < rf_dly; i++) begin
        @(negedge clk);
        chk("refill_hold", 32'(bus.refill_req_o), 32'd1);
      end
      bus.refill_ack_i = 1'b1;
      @(posedge clk);
      #1 bus.refill_ack_i = 1'b0;
      @(negedge clk);
      chk("miss_latency", 32'(bus.resp_valid_o), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid_i   = 1'b0;
    bus.req_index_i   = '0;
    bus.tag_hit_i     = '0;
    bus.way_valid_i   = '0;
    bus.way_dirty_i   = '0;
    bus.plru_victim_i = '0;
    bus.wb_ack_i      = 1'b0;
    bus.refill_ack_i  = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready",      32'(bus.req_ready_o),  32'd0);
    chk("rst_wb",         32'(bus.wb_req_o),     32'd0);
    chk("rst_refill",     32'(bus.refill_req_o), 32'd0);
    chk("rst_resp",       32'(bus.resp_valid_o), 32'd0);
    chk("rst_plru_valid", 32'(bus.plru_valid_o), 32'd0);
    chk("rst_plru_index", 32'(bus.plru_index_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(bus.req_ready_o), 32'd1);

    // Spurious acks in IDLE are ignored
    bus.wb_ack_i     = 1'b1;
    bus.refill_ack_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("spurious_ready",  32'(bus.req_ready_o),  32'd1);
      chk("spurious_refill", 32'(bus.refill_req_o), 32'd0);
    end
    bus.wb_ack_i     = 1'b0;
    bus.refill_ack_i = 1'b0;

    // Reset during WB: wb_req drops asynchronously, no touch afterwards
    drive_req(INDEX_W'(9), 8'h00, 8'hFF, 8'h40, 3'd6);
    wait_hi(1, "rst_wb_req");
    chk("pre_rst_wb_way", 32'(bus.wb_way_o), 32'd6);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_wb_drop", 32'(bus.wb_req_o),    32'd0);
    chk("rst_async_ready",   32'(bus.req_ready_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_release_ready", 32'(bus.req_ready_o), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_no_touch", 32'(bus.plru_valid_o), 32'd0);
    end

    // Hit on way 5
    do_req(INDEX_W'(5),   8'b0010_0000, 8'hFF,        8'h00, 3'd0, 0, 0);
    // Miss with invalid way 3, refill ack after 4 cycles
    do_req(INDEX_W'(17),  8'h00,        8'b1111_0111, 8'hFF, 3'd7, 0, 4);
    // Dirty victim 6: writeback then refill
    do_req(INDEX_W'(300), 8'h00,        8'hFF,        8'h40, 3'd6, 2, 1);
    // Clean victim 2: refill directly, ack in first cycle
    do_req(INDEX_W'(1023),8'h00,        8'hFF,        8'h00, 3'd2, 0, 0);
    // Multi-hot hit: lowest way wins
    do_req(INDEX_W'(42),  8'b1000_0100, 8'hFF,        8'hFF, 3'd7, 0, 0);

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
`ifdef L2_WAY_SEL_PERF_EN
    chk("perf_hit",  bus.perf_hit_o,  32'd2);
    chk("perf_miss", bus.perf_miss_o, 32'd3);
    chk("perf_wb",   bus.perf_wb_o,   32'd1);
`else
    chk("perf_hit",  bus.perf_hit_o,  32'd0);
    chk("perf_miss", bus.perf_miss_o, 32'd0);
    chk("perf_wb",   bus.perf_wb_o,   32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
